// File: rtl/zle_enc_param.sv
// rtl/zle_enc_param.sv - parametrised zero run-length encoder with registered output
// Optional end-of-stream flush is compiled in with `define ZLE_EOS_EN.
module zle_enc_param #(
    parameter int W       = 7,
    parameter int MAX_RUN = 2**W - 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_v,
    output logic         i_b,
    input  logic [W-1:0] i_d,
    input  logic         i_eos,
    output logic         o_v,
    input  logic         o_b,
    output logic [W:0]   o_d,
    output logic         o_eos
);
    localparam int            CW      = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_RUN);

    typedef enum logic [1:0] {
        START   = 2'd0,
        ZEROS   = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  hd;
    logic          heos;
    logic          free;
    logic          acc;
    logic          eos_in;
    logic          zero_in;

`ifdef ZLE_EOS_EN
    assign eos_in = i_eos;
`else
    logic unused_eos;
    assign unused_eos = i_eos;
    assign eos_in     = 1'b0;
`endif

    // The output register can take a new token when it is empty or being drained this edge.
    assign free    = !o_v || !o_b;
    assign i_b     = reset || !free || (state == PENDING);
    assign acc     = i_v && !i_b;
    assign zero_in = (i_d == '0);
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= START;
            cnt   <= '0;
            hd    <= '0;
            heos  <= 1'b0;
            o_v   <= 1'b0;
            o_d   <= '0;
            o_eos <= 1'b0;
        end else begin
            if (free) begin
                o_v <= 1'b0;
            end
            case (state)
                START: begin
                    if (acc) begin
                        if (!zero_in) begin
                            o_v   <= 1'b1;
                            o_d   <= {1'b0, i_d};
                            o_eos <= eos_in;
                        end else if (eos_in) begin
                            o_v   <= 1'b1;
                            o_d   <= {1'b1, W'(1)};
                            o_eos <= 1'b1;
                        end else begin
                            cnt   <= CW'(1);
                            state <= ZEROS;
                        end
                    end
                end
                ZEROS: begin
                    if (acc) begin
                        if (zero_in) begin
                            // A full-length run closes immediately; the next zero opens a new one.
                            if ((cnt_inc == RUN_MAX) || eos_in) begin
                                o_v   <= 1'b1;
                                o_d   <= {1'b1, W'(cnt_inc)};
                                o_eos <= eos_in;
                                cnt   <= '0;
                                state <= START;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            o_v   <= 1'b1;
                            o_d   <= {1'b1, W'(cnt)};
                            o_eos <= 1'b0;
                            hd    <= i_d;
                            heos  <= eos_in;
                            cnt   <= '0;
                            state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (free) begin
                        o_v   <= 1'b1;
                        o_d   <= {1'b0, hd};
                        o_eos <= heos;
                        hd    <= '0;
                        heos  <= 1'b0;
                        state <= START;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= START;
                end
            endcase
        end
    end
endmodule

// File: doc/zle_enc_param.md
# zle_enc_param

Parametrised zero run-length encoder: FSM and datapath in one block, with registered output and optional end-of-stream flush. Replaces the hand-coded 7→8-bit ZLE FSM + separate datapath pair. Sits between a valid/busy producer stream and a valid/busy consumer stream. Each nonzero input word is emitted as a literal token; each run of zero words is emitted as one run-count token.

## Interface
- W, 7: input data width; output token width is W+1.
- MAX_RUN, 2**W-1: longest run per run token. Legal range 2 ≤ MAX_RUN ≤ 2**W-1.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared while high.
- i_v  in  1  input word valid.
- i_b  out  1  input busy; a word transfers on a rising edge with i_v=1, i_b=0.
- i_d  in  W  input data word.
- i_eos  in  1  end-of-stream mark on the current input word. Used only with ZLE_EOS_EN.
- o_v  out  1  output token valid (registered).
- o_b  in  1  output busy; a token transfers on a rising edge with o_v=1, o_b=0.
- o_d  out  W+1  output token: {1'b0, data} is a literal; {1'b1, count} is a zero run of length count (1..MAX_RUN).
- o_eos  out  1  end-of-stream mark on the current output token (registered).

## Operation
- Output register (o_v, o_d, o_eos) is "free" when o_v=0 or o_b=0. It loads at most one token per cycle and otherwise holds.
- Run counter cnt is $clog2(MAX_RUN+1) bits wide. Arithmetic never wraps: cnt never exceeds MAX_RUN.
- Hold register (hd, heos) stores a literal deferred behind a run token.
- i_b = reset | !free | (state==PENDING). This is combinational from state, o_v and o_b only, never from i_v.
- States and transitions on accepted input x, written as transition → emitted token:
  - START, x≠0: → START, emit {0,x}.
  - START, x=0: cnt=1, → ZEROS, no emit.
  - ZEROS, x=0, cnt+1==MAX_RUN: → START, emit {1,MAX_RUN}.
  - ZEROS, x=0, otherwise: cnt=cnt+1, no emit.
  - ZEROS, x≠0: emit {1,cnt}, load hold with {0,x}, → PENDING.
  - PENDING: input blocked. When free, emit the hold contents and → START.
- In START and ZEROS with no input accepted, nothing is emitted and state holds.
- A run of exactly MAX_RUN zeros produces a single run token. The next zero starts a new run.
- Unreachable state encoding: recover to START on the next clock.

## Timing
- Reset values: state=START, cnt=0, hold=0, o_v=0, o_d=0, o_eos=0, i_b=1.
- With reset low and output free, i_b=0 in the first cycle after reset release.
- Latency: a token appears on o_* in the cycle after the accepting edge. A deferred literal appears one cycle after its run token leaves the output register.
- Throughput: one input per cycle in START/ZEROS with o_b=0. Each literal that terminates a run costs one extra input stall cycle (PENDING).
- Simultaneous output drain and load in the same cycle is required: back-to-back tokens with no bubble.
- Stall: while o_b=1 with o_v=1, the o_* signals hold stable and no input is accepted.
- Reset mid-run or mid-PENDING discards cnt and hold. No token is emitted for the partial run.

## Configuration
- ZLE_EOS_EN defined: an accepted word with i_eos=1 terminates the stream.
  - START, x≠0: emit {0,x} with o_eos=1.
  - START, x=0: emit {1,1} with o_eos=1.
  - ZEROS, x=0: emit {1,cnt+1} (at most MAX_RUN) with o_eos=1, → START.
  - ZEROS, x≠0: emit {1,cnt} with o_eos=0, then the held literal with o_eos=1.
  - No run ever spans an EOS.
- ZLE_EOS_EN undefined: i_eos is ignored, o_eos is constant 0, and runs end only at MAX_RUN or at a nonzero word.

## Test plan
- W=7, o_b=0, input 5,0,0,0,9 → tokens 0x05, 0x83, 0x09. i_b is high for exactly one cycle, after 9 is accepted.
- W=7, MAX_RUN=127, 130 zeros then 1 → tokens 0xFF, 0x83, 0x01.
- W=4, MAX_RUN=5, 5 zeros → single token 0x15. Then zero, 3 → tokens 0x11, 0x03.
- o_b held high 3 cycles while o_v=1 during stream 0,7 → o_d/o_v stable, i_b=1, no tokens lost or duplicated, and order is preserved after release.
- ZLE_EOS_EN, input 0,0 with i_eos on the second word → token 0x82 with o_eos=1. Then input 4 → token 0x04 with o_eos=0.
- Assert reset for 1 cycle during ZEROS (cnt=2) → o_v=0 and i_b=1 during reset. After release, input 3 → single token 0x03.
